// File: rtl/issue_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : issue_pkg                                                        |
// | Purpose : Shared opcode constants, instruction classes, scheduler state    |
// |           encodings and register-use helpers for issue_pair_scheduler.     |
// | Ports   : none (package)                                                   |
// | Config  : ISSUE_SCHED_PERF_EN (used by the top only)                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package issue_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'd0,
      CLS_LS   = 2'd1,
      CLS_CTRL = 2'd2,
      CLS_SER  = 2'd3
   } instr_class_e;

   // Scheduler states kept as plain 2-bit constants for legacy tools.
   typedef logic [1:0] sched_state_e;
   localparam sched_state_e ST_EMPTY  = 2'd0;
   localparam sched_state_e ST_PAIR   = 2'd1;
   localparam sched_state_e ST_SECOND = 2'd2;

   function automatic instr_class_e instr_class(input logic [6:0] op);
      instr_class_e cls;
      case (op)
         OP_LOAD, OP_STORE:           cls = CLS_LS;
         OP_BRANCH, OP_JAL, OP_JALR:  cls = CLS_CTRL;
         OP_IMM, OP_REG, OP_LUI,
         OP_AUIPC:                    cls = CLS_ALU;
         default:                     cls = CLS_SER;
      endcase
      return cls;
   endfunction

   // x0 is never a real destination, so it never creates a hazard.
   function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
      return (op != OP_BRANCH) && (op != OP_STORE) && (rd != 5'd0);
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/issue_pair_check.sv
// +----------------------------------------------------------------------------+
// | Module  : issue_pair_check                                                 |
// | Purpose : Combinational pair analysis: class decode, intra-pair RAW/WAW,   |
// |           dual-issue decision and slot routing.                            |
// | Ports   : op0_i/rd0_i            older instr opcode and rd                 |
// |           op1_i/rd1_i/rs1_1_i/rs2_1_i  younger instr fields                |
// |           instr1_valid_i         younger instr present                     |
// |           dual_ok_o              pair may issue together                   |
// |           dual_i0_ls_o           dual issue: older goes to LS slot         |
// |           single_i0_ls_o         single issue of older: LS slot            |
// |           single_i1_ls_o         single issue of younger: LS slot          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module issue_pair_check
   import issue_pkg::*;
(
   input  logic [6:0] op0_i,
   input  logic [4:0] rd0_i,
   input  logic [6:0] op1_i,
   input  logic [4:0] rd1_i,
   input  logic [4:0] rs1_1_i,
   input  logic [4:0] rs2_1_i,
   input  logic       instr1_valid_i,
   output logic       dual_ok_o,
   output logic       dual_i0_ls_o,
   output logic       single_i0_ls_o,
   output logic       single_i1_ls_o
);

   instr_class_e cls0;
   instr_class_e cls1;
   logic         wr0;
   logic         raw;
   logic         waw;

   always_comb begin
      cls0 = instr_class(op0_i);
      cls1 = instr_class(op1_i);
      wr0  = writes_rd(op0_i, rd0_i);
      raw  = wr0 && ((uses_rs1(op1_i) && (rs1_1_i == rd0_i)) ||
                     (uses_rs2(op1_i) && (rs2_1_i == rd0_i)));
      waw  = wr0 && writes_rd(op1_i, rd1_i) && (rd1_i == rd0_i);

      dual_ok_o = instr1_valid_i && !raw && !waw &&
                  (cls0 != CLS_CTRL) && (cls0 != CLS_SER) && (cls1 != CLS_SER) &&
                  !((cls0 == CLS_LS) && (cls1 == CLS_LS)) &&
                  !((cls0 == CLS_CTRL) && (cls1 == CLS_CTRL));

      // Older CTRL never dual-issues, so the older instr lands in LS only if it
      // is a load/store itself or the younger one claims the BRA slot.
      dual_i0_ls_o   = (cls0 == CLS_LS) || (cls1 == CLS_CTRL);
      single_i0_ls_o = (cls0 == CLS_LS);
      single_i1_ls_o = (cls1 == CLS_LS);
   end

endmodule

`default_nettype wire

// File: rtl/issue_pair_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module  : issue_pair_scheduler                                             |
// | Purpose : Buffers one fetched instruction pair and issues it to the BRA   |
// |           and LS decode slots, dual where legal, otherwise over two cycles.|
// | Ports   : clk_i, rstn_i (async active-low)                                 |
// |           fetch_valid_i/fetch_instr0_i/fetch_instr1_i/fetch_instr1_valid_i |
// |           fetch_pc_i, fetch_ready_o       fetch handshake                  |
// |           issue_ready_i, flush_i           decode handshake / redirect     |
// |           instr_*_o, pc_*_o, *_valid_o     slot outputs                     |
// |           prio_o (1: LS older), split_o (first half of split pair)         |
// |           perf_dual_o/perf_split_o/perf_single_o  (ISSUE_SCHED_PERF_EN)    |
// | Config  : `define ISSUE_SCHED_PERF_EN adds issue-kind counters             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module issue_pair_scheduler
   import issue_pkg::*;
#(
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            fetch_valid_i,
   input  logic [31:0]     fetch_instr0_i,
   input  logic [31:0]     fetch_instr1_i,
   input  logic            fetch_instr1_valid_i,
   input  logic [PC_W-1:0] fetch_pc_i,
   output logic            fetch_ready_o,
   input  logic            issue_ready_i,
   input  logic            flush_i,
   output logic [31:0]     instr_bra_o,
   output logic [31:0]     instr_ls_o,
   output logic [PC_W-1:0] pc_bra_o,
   output logic [PC_W-1:0] pc_ls_o,
   output logic            bra_valid_o,
   output logic            ls_valid_o,
   output logic            prio_o,
   output logic            split_o
`ifdef ISSUE_SCHED_PERF_EN
   ,
   output logic [31:0]     perf_dual_o,
   output logic [31:0]     perf_split_o,
   output logic [31:0]     perf_single_o
`endif
);

   sched_state_e    state_q, state_d;
   logic [31:0]     instr0_q, instr0_d;
   logic [31:0]     instr1_q, instr1_d;
   logic            instr1_valid_q, instr1_valid_d;
   logic [PC_W-1:0] pc_q, pc_d;

   logic            dual_ok;
   logic            dual_i0_ls;
   logic            single_i0_ls;
   logic            single_i1_ls;
   logic            drain;
   logic            accept;
   logic [PC_W-1:0] pc1;

   issue_pair_check u_check (
      .op0_i          (instr0_q[6:0]),
      .rd0_i          (instr0_q[11:7]),
      .op1_i          (instr1_q[6:0]),
      .rd1_i          (instr1_q[11:7]),
      .rs1_1_i        (instr1_q[19:15]),
      .rs2_1_i        (instr1_q[24:20]),
      .instr1_valid_i (instr1_valid_q),
      .dual_ok_o      (dual_ok),
      .dual_i0_ls_o   (dual_i0_ls),
      .single_i0_ls_o (single_i0_ls),
      .single_i1_ls_o (single_i1_ls)
   );

   always_comb begin
      pc1 = pc_q + PC_W'(4);
      // Buffer empties on this issue: dual or lone instr from PAIR, or any SECOND.
      drain = ((state_q == ST_PAIR) && (dual_ok || !instr1_valid_q)) ||
              (state_q == ST_SECOND);
      fetch_ready_o = !flush_i && ((state_q == ST_EMPTY) || (issue_ready_i && drain));
      accept = fetch_valid_i && fetch_ready_o;
   end

   // Slot output muxing
   always_comb begin
      instr_bra_o = NOP_INSTR;
      instr_ls_o  = NOP_INSTR;
      pc_bra_o    = '0;
      pc_ls_o     = '0;
      bra_valid_o = 1'b0;
      ls_valid_o  = 1'b0;
      prio_o      = 1'b0;
      split_o     = 1'b0;
      if (!flush_i) begin
         case (state_q)
            ST_PAIR: begin
               if (dual_ok) begin
                  bra_valid_o = 1'b1;
                  ls_valid_o  = 1'b1;
                  prio_o      = dual_i0_ls;
                  if (dual_i0_ls) begin
                     instr_ls_o  = instr0_q;  pc_ls_o  = pc_q;
                     instr_bra_o = instr1_q;  pc_bra_o = pc1;
                  end else begin
                     instr_bra_o = instr0_q;  pc_bra_o = pc_q;
                     instr_ls_o  = instr1_q;  pc_ls_o  = pc1;
                  end
               end else begin
                  split_o = instr1_valid_q;
                  prio_o  = single_i0_ls;
                  if (single_i0_ls) begin
                     instr_ls_o = instr0_q;  pc_ls_o = pc_q;  ls_valid_o = 1'b1;
                  end else begin
                     instr_bra_o = instr0_q; pc_bra_o = pc_q; bra_valid_o = 1'b1;
                  end
               end
            end
            ST_SECOND: begin
               prio_o = single_i1_ls;
               if (single_i1_ls) begin
                  instr_ls_o = instr1_q;  pc_ls_o = pc1;  ls_valid_o = 1'b1;
               end else begin
                  instr_bra_o = instr1_q; pc_bra_o = pc1; bra_valid_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and buffer load
   always_comb begin
      state_d        = state_q;
      instr0_d       = instr0_q;
      instr1_d       = instr1_q;
      instr1_valid_d = instr1_valid_q;
      pc_d           = pc_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else if (accept) begin
         state_d        = ST_PAIR;
         instr0_d       = fetch_instr0_i;
         instr1_d       = fetch_instr1_i;
         instr1_valid_d = fetch_instr1_valid_i;
         pc_d           = fetch_pc_i;
      end else if (issue_ready_i && (state_q != ST_EMPTY)) begin
         state_d = drain ? ST_EMPTY : ST_SECOND;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q        <= ST_EMPTY;
         instr0_q       <= NOP_INSTR;
         instr1_q       <= NOP_INSTR;
         instr1_valid_q <= 1'b0;
         pc_q           <= '0;
      end else begin
         state_q        <= state_d;
         instr0_q       <= instr0_d;
         instr1_q       <= instr1_d;
         instr1_valid_q <= instr1_valid_d;
         pc_q           <= pc_d;
      end
   end

`ifdef ISSUE_SCHED_PERF_EN
   logic [31:0] perf_dual_q, perf_dual_d;
   logic [31:0] perf_split_q, perf_split_d;
   logic [31:0] perf_single_q, perf_single_d;
   logic        issue_fire;

   always_comb begin
      issue_fire    = issue_ready_i && (bra_valid_o || ls_valid_o);
      perf_dual_d   = perf_dual_q;
      perf_split_d  = perf_split_q;
      perf_single_d = perf_single_q;
      if (issue_fire) begin
         if (bra_valid_o && ls_valid_o) perf_dual_d   = perf_dual_q + 32'd1;
         else if (split_o)              perf_split_d  = perf_split_q + 32'd1;
         else                           perf_single_d = perf_single_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         perf_dual_q   <= '0;
         perf_split_q  <= '0;
         perf_single_q <= '0;
      end else begin
         perf_dual_q   <= perf_dual_d;
         perf_split_q  <= perf_split_d;
         perf_single_q <= perf_single_d;
      end
   end

   assign perf_dual_o   = perf_dual_q;
   assign perf_split_o  = perf_split_q;
   assign perf_single_o = perf_single_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_pair_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_issue_pair_scheduler                                          |
// | Purpose : Scoreboard bench for issue_pair_scheduler. Expected slot issues |
// |           are queued as pairs are driven and compared on each issue.      |
// | Config  : ISSUE_SCHED_PERF_EN also checks the issue-kind counters          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_issue_pair_scheduler;

   localparam logic [31:0] NOP = 32'h0000_0000;

   // Instruction encodings
   localparam logic [31:0] ADDI_X1  = 32'h0010_0093;  // addi x1,x0,1
   localparam logic [31:0] LW_X2    = 32'h0001_A103;  // lw x2,0(x3)
   localparam logic [31:0] ADDI_X5  = 32'h0010_0293;  // addi x5,x0,1
   localparam logic [31:0] ADD_X6   = 32'h0052_8333;  // add x6,x5,x5
   localparam logic [31:0] LW_X1    = 32'h0001_2083;  // lw x1,0(x2)
   localparam logic [31:0] SW_X3    = 32'h0032_2223;  // sw x3,4(x4)
   localparam logic [31:0] BEQ      = 32'h0020_8463;  // beq x1,x2,+8
   localparam logic [31:0] ADDI_X7  = 32'h0030_0393;  // addi x7,x0,3
   localparam logic [31:0] LW_X8    = 32'h0004_A403;  // lw x8,0(x9)
   localparam logic [31:0] ADDI_X10 = 32'h0050_0513;  // addi x10,x0,5
   localparam logic [31:0] JAL      = 32'h0100_006F;  // jal x0,+16
   localparam logic [31:0] ECALL    = 32'h0000_0073;  // serialising

   typedef struct packed {
      logic        bv;
      logic [31:0] bi;
      logic [31:0] bp;
      logic        lv;
      logic [31:0] li;
      logic [31:0] lp;
      logic        prio;
      logic        split;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        fetch_valid;
   logic [31:0] fetch_instr0;
   logic [31:0] fetch_instr1;
   logic        fetch_instr1_valid;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        issue_ready;
   logic        flush;
   logic [31:0] instr_bra, instr_ls, pc_bra, pc_ls;
   logic        bra_valid, ls_valid, prio, split;
`ifdef ISSUE_SCHED_PERF_EN
   logic [31:0] perf_dual, perf_split, perf_single;
   int          exp_dual, exp_split, exp_single;
`endif

   int   n_cmp;
   int   n_bad;
   exp_t sb_q[$];
   exp_t mon_e;

   issue_pair_scheduler #(.PC_W(32), .NOP_INSTR(NOP)) dut (
      .clk_i                (clk),
      .rstn_i               (rstn),
      .fetch_valid_i        (fetch_valid),
      .fetch_instr0_i       (fetch_instr0),
      .fetch_instr1_i       (fetch_instr1),
      .fetch_instr1_valid_i (fetch_instr1_valid),
      .fetch_pc_i           (fetch_pc),
      .fetch_ready_o        (fetch_ready),
      .issue_ready_i        (issue_ready),
      .flush_i              (flush),
      .instr_bra_o          (instr_bra),
      .instr_ls_o           (instr_ls),
      .pc_bra_o             (pc_bra),
      .pc_ls_o              (pc_ls),
      .bra_valid_o          (bra_valid),
      .ls_valid_o           (ls_valid),
      .prio_o               (prio),
      .split_o              (split)
`ifdef ISSUE_SCHED_PERF_EN
      ,
      .perf_dual_o          (perf_dual),
      .perf_split_o         (perf_split),
      .perf_single_o        (perf_single)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t rec_dual(input logic [31:0] bi, input logic [31:0] bp,
                                     input logic [31:0] li, input logic [31:0] lp,
                                     input logic pr);
      exp_t e;
      e = '{bv: 1'b1, bi: bi, bp: bp, lv: 1'b1, li: li, lp: lp, prio: pr, split: 1'b0};
      return e;
   endfunction

   function automatic exp_t rec_bra(input logic [31:0] i, input logic [31:0] pc,
                                    input logic sp);
      exp_t e;
      e = '{bv: 1'b1, bi: i, bp: pc, lv: 1'b0, li: NOP, lp: 32'd0, prio: 1'b0, split: sp};
      return e;
   endfunction

   function automatic exp_t rec_ls(input logic [31:0] i, input logic [31:0] pc,
                                   input logic sp);
      exp_t e;
      e = '{bv: 1'b0, bi: NOP, bp: 32'd0, lv: 1'b1, li: i, lp: pc, prio: 1'b1, split: sp};
      return e;
   endfunction

   // Scoreboard: every real issue must match the oldest expected record.
   always @(negedge clk) begin
      if (rstn && issue_ready && (bra_valid || ls_valid)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_issue", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("bra_valid", {31'd0, bra_valid}, {31'd0, mon_e.bv});
            chk("bra_instr", instr_bra, mon_e.bi);
            chk("bra_pc",    pc_bra,    mon_e.bp);
            chk("ls_valid",  {31'd0, ls_valid},  {31'd0, mon_e.lv});
            chk("ls_instr",  instr_ls,  mon_e.li);
            chk("ls_pc",     pc_ls,     mon_e.lp);
            chk("prio",      {31'd0, prio},      {31'd0, mon_e.prio});
            chk("split",     {31'd0, split},     {31'd0, mon_e.split});
`ifdef ISSUE_SCHED_PERF_EN
            if (mon_e.bv && mon_e.lv) exp_dual++;
            else if (mon_e.split)     exp_split++;
            else                      exp_single++;
`endif
         end
      end
   end

   task automatic drive_pair(input logic [31:0] i0, input logic [31:0] i1,
                             input logic i1v, input logic [31:0] pc);
      fetch_valid        = 1'b1;
      fetch_instr0       = i0;
      fetch_instr1       = i1;
      fetch_instr1_valid = i1v;
      fetch_pc           = pc;
   endtask

   // Holds the pair until accepted; returns just after the accepting edge.
   task automatic wait_accept();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (fetch_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("fetch_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [31:0] i0, input logic [31:0] i1,
                            input logic i1v, input logic [31:0] pc);
      @(posedge clk);
      #1;
      drive_pair(i0, i1, i1v, pc);
      wait_accept();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
`ifdef ISSUE_SCHED_PERF_EN
      exp_dual = 0; exp_split = 0; exp_single = 0;
`endif
      rstn = 1'b0;
      fetch_valid = 1'b0;
      fetch_instr0 = NOP;
      fetch_instr1 = NOP;
      fetch_instr1_valid = 1'b0;
      fetch_pc = 32'd0;
      issue_ready = 1'b1;
      flush = 1'b0;

      // Reset state
      #1;
      chk("rst_bra_valid", {31'd0, bra_valid}, 32'd0);
      chk("rst_ls_valid",  {31'd0, ls_valid},  32'd0);
      chk("rst_prio",      {31'd0, prio},      32'd0);
      chk("rst_split",     {31'd0, split},     32'd0);
      chk("rst_bra_instr", instr_bra, NOP);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);

      // 1: addi + lw dual
      sb_q.push_back(rec_dual(ADDI_X1, 32'h100, LW_X2, 32'h104, 1'b0));
      send_pair(ADDI_X1, LW_X2, 1'b1, 32'h100);
      repeat (2) @(negedge clk);

      // 2: RAW split, fetch stalled on first half
      sb_q.push_back(rec_bra(ADDI_X5, 32'h200, 1'b1));
      sb_q.push_back(rec_bra(ADD_X6,  32'h204, 1'b0));
      send_pair(ADDI_X5, ADD_X6, 1'b1, 32'h200);
      @(negedge clk);
      chk("raw_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      repeat (2) @(negedge clk);

      // 3: two memory ops split, LS slot older
      sb_q.push_back(rec_ls(LW_X1, 32'h300, 1'b1));
      sb_q.push_back(rec_ls(SW_X3, 32'h304, 1'b0));
      send_pair(LW_X1, SW_X3, 1'b1, 32'h300);
      repeat (3) @(negedge clk);

      // 4: older branch splits; flush in SECOND drops the addi
      sb_q.push_back(rec_bra(BEQ, 32'h400, 1'b1));
      send_pair(BEQ, ADDI_X7, 1'b1, 32'h400);
      @(negedge clk);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_bra_valid", {31'd0, bra_valid}, 32'd0);
      chk("flush_ls_valid",  {31'd0, ls_valid},  32'd0);
      chk("flush_bra_instr", instr_bra, NOP);
      chk("flush_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("postflush_bra_valid", {31'd0, bra_valid}, 32'd0);
      chk("postflush_fetch_ready", {31'd0, fetch_ready}, 32'd1);

      // 5: stalled dual pair holds, then refill on the draining cycle
      issue_ready = 1'b0;
      sb_q.push_back(rec_dual(ADDI_X1, 32'h500, LW_X2, 32'h504, 1'b0));
      sb_q.push_back(rec_dual(ADDI_X10, 32'h604, LW_X8, 32'h600, 1'b1));
      send_pair(ADDI_X1, LW_X2, 1'b1, 32'h500);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_bra_instr", instr_bra, ADDI_X1);
         chk("stall_ls_instr",  instr_ls,  LW_X2);
         chk("stall_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      issue_ready = 1'b1;
      drive_pair(LW_X8, ADDI_X10, 1'b1, 32'h600);
      wait_accept();
      repeat (2) @(negedge clk);

      // Extra routing cases: ALU+CTRL dual, lone load, serialising split
      sb_q.push_back(rec_dual(JAL, 32'h704, ADDI_X1, 32'h700, 1'b1));
      send_pair(ADDI_X1, JAL, 1'b1, 32'h700);
      sb_q.push_back(rec_ls(LW_X2, 32'h800, 1'b0));
      send_pair(LW_X2, NOP, 1'b0, 32'h800);
      sb_q.push_back(rec_bra(ECALL,   32'h900, 1'b1));
      sb_q.push_back(rec_bra(ADDI_X1, 32'h904, 1'b0));
      send_pair(ECALL, ADDI_X1, 1'b1, 32'h900);
      repeat (3) @(negedge clk);

      // 6: reset mid-SECOND
      sb_q.push_back(rec_bra(ADDI_X5, 32'hA00, 1'b1));
      send_pair(ADDI_X5, ADD_X6, 1'b1, 32'hA00);
      @(negedge clk);
      @(posedge clk);
      #2;
      chk("second_bra_instr", instr_bra, ADD_X6);
`ifdef ISSUE_SCHED_PERF_EN
      chk("perf_dual",   perf_dual,   exp_dual);
      chk("perf_split",  perf_split,  exp_split);
      chk("perf_single", perf_single, exp_single);
`endif
      rstn = 1'b0;
      #1;
      chk("arst_bra_valid", {31'd0, bra_valid}, 32'd0);
      chk("arst_ls_valid",  {31'd0, ls_valid},  32'd0);
      chk("arst_split",     {31'd0, split},     32'd0);
      chk("arst_prio",      {31'd0, prio},      32'd0);
      chk("arst_bra_instr", instr_bra, NOP);
      chk("arst_bra_pc",    pc_bra,    32'd0);
`ifdef ISSUE_SCHED_PERF_EN
      chk("arst_perf_dual",   perf_dual,   32'd0);
      chk("arst_perf_split",  perf_split,  32'd0);
      chk("arst_perf_single", perf_single, 32'd0);
`endif
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("arst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
      chk("arst_idle_valid",  {31'd0, bra_valid},   32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
